// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the fetch front-end state encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-cache side plus the decode-facing queue head.
interface fetch_unit_if #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic [WORD_W-1:0] imemload;
  logic              ihit;
  logic              dmem_busy;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt_req;
  logic              deq_ready;
  logic              instr_valid;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc4;
  logic [CNT_W-1:0]  count;
  logic              halted;

  modport master (
    output imemREN, imemaddr, instr_valid, instr, instr_pc4, count, halted,
    input  imemload, ihit, dmem_busy, redirect, redirect_pc, halt_req, deq_ready
  );

  modport slave (
    input  imemREN, imemaddr, instr_valid, instr, instr_pc4, count, halted,
    output imemload, ihit, dmem_busy, redirect, redirect_pc, halt_req, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry circular buffer of {instr, pc+4}; flush clears pointers and count
// and wins over enq/deq in the same cycle. Head is read combinationally.
module fetch_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  localparam int ENT_W = 2 * WORD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [ENT_W-1:0] enq_dat,
  input  logic             deq,
  input  logic             flush,
  output logic [ENT_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_deq = deq & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_enq = enq & (~full | do_deq);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_enq && !flush) mem[wr_ptr] <= enq_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer, prefetch queue and sticky halt.
// Redirect flushes the queue in one cycle; HALTED is left only by reset.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int              WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int              DEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state, state_nxt;
  logic [WORD_W-1:0] pc, pc_nxt, pc_plus4;
  logic              enq, deq, flush, can_enq, q_empty, q_full;
  logic [CNT_W-1:0]  q_count;
  logic [2*WORD_W-1:0] head;

  assign pc_plus4 = pc + WORD_W'(4);
  assign deq      = ~q_empty & bus.deq_ready;
  assign can_enq  = ~q_full | deq;
  assign flush    = bus.redirect & (state != HALTED);

  // Gating with rst keeps the request low while reset is held.
  assign bus.imemREN  = ~rst & (state == FETCH) & ~bus.dmem_busy & can_enq & ~bus.redirect;
  assign enq          = bus.imemREN & bus.ihit;
  assign bus.imemaddr = pc;

  assign bus.instr_valid = ~q_empty;
  assign bus.instr       = head[2*WORD_W-1:WORD_W];
  assign bus.instr_pc4   = head[WORD_W-1:0];
  assign bus.count       = q_count;
  assign bus.halted      = (state == HALTED);

  fetch_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .enq     (enq),
    .enq_dat ({bus.imemload, pc_plus4}),
    .deq     (deq & ~flush),
    .flush   (flush),
    .head    (head),
    .count   (q_count),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (flush)    pc_nxt = {bus.redirect_pc[WORD_W-1:2], 2'b00};
    else if (enq) pc_nxt = pc_plus4;
    case (state)
      FETCH:   if (bus.halt_req) state_nxt = DRAIN;
      DRAIN:   if (q_empty)      state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= PC_INIT;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns address ^ 0xDEAD0000.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_unit_if #(.WORD_W(32), .DEPTH(4)) bus ();

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imemload = bus.imemaddr ^ 32'hDEAD0000;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs are then changed and settled before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ihit = 0; bus.dmem_busy = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.halt_req = 0; bus.deq_ready = 0;
    #12;
    chk("rst_count",   word_t'(bus.count), 0);
    chk("rst_valid",   word_t'(bus.instr_valid), 0);
    chk("rst_halted",  word_t'(bus.halted), 0);
    chk("rst_ren",     word_t'(bus.imemREN), 0);
    chk("rst_addr",    bus.imemaddr, 32'h0);
    @(negedge clk); rst = 0;
    bus.ihit = 1;
    #1;
    chk("t1_ren0", word_t'(bus.imemREN), 1);

    // fill the queue with deq_ready low
    tick(); #1;
    chk("t1_valid", word_t'(bus.instr_valid), 1);
    chk("t1_instr", bus.instr, 32'hDEAD0000);
    chk("t1_pc4",   bus.instr_pc4, 32'h4);
    chk("t1_cnt1",  word_t'(bus.count), 1);
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("t1_cnt4", word_t'(bus.count), 4);
    chk("t1_addr", bus.imemaddr, 32'h10);
    chk("t1_ren",  word_t'(bus.imemREN), 0);
    tick(); #1;
    chk("t1_hold_cnt",  word_t'(bus.count), 4);
    chk("t1_hold_addr", bus.imemaddr, 32'h10);

    // full queue with simultaneous enqueue and dequeue
    bus.deq_ready = 1; #1;
    chk("t2_ren", word_t'(bus.imemREN), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pc4", bus.instr_pc4, 32'h4 + 32'(4 * i));
      chk("t2_cnt", word_t'(bus.count), 4);
      tick();
    end
    #1;
    chk("t2_pc4_end", bus.instr_pc4, 32'h14);
    chk("t2_instr",   bus.instr, 32'hDEAD0010);
    chk("t2_addr",    bus.imemaddr, 32'h20);

    // drop to count 3, then redirect with a concurrent ihit
    bus.ihit = 0;
    tick();
    bus.deq_ready = 0; bus.redirect = 1; bus.redirect_pc = 32'h00000103; bus.ihit = 1;
    #1;
    chk("t3_cnt3",  word_t'(bus.count), 3);
    chk("t3_ren_r", word_t'(bus.imemREN), 0);
    tick();
    bus.redirect = 0; bus.ihit = 0;
    #1;
    chk("t3_cnt0",  word_t'(bus.count), 0);
    chk("t3_valid", word_t'(bus.instr_valid), 0);
    chk("t3_addr",  bus.imemaddr, 32'h100);
    chk("t3_ren",   word_t'(bus.imemREN), 1);
    bus.ihit = 1;
    tick();
    bus.ihit = 0;
    #1;
    chk("t3_instr", bus.instr, 32'hDEAD0100);
    chk("t3_pc4",   bus.instr_pc4, 32'h104);
    chk("t3_cnt1",  word_t'(bus.count), 1);

    // data-side busy blocks fetch
    bus.dmem_busy = 1; bus.ihit = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_ren",  word_t'(bus.imemREN), 0);
      chk("t4_cnt",  word_t'(bus.count), 1);
      chk("t4_addr", bus.imemaddr, 32'h104);
      tick();
    end
    bus.dmem_busy = 0; #1;
    chk("t4_ren_resume", word_t'(bus.imemREN), 1);
    tick();
    bus.ihit = 0;
    #1;
    chk("t4_cnt2", word_t'(bus.count), 2);
    chk("t4_addr2", bus.imemaddr, 32'h108);

    // halt drains the queue, then sticks
    bus.halt_req = 1; bus.deq_ready = 1;
    tick();
    bus.halt_req = 0; bus.ihit = 1;
    #1;
    chk("t5_ren_drain", word_t'(bus.imemREN), 0);
    chk("t5_cnt1",      word_t'(bus.count), 1);
    tick(); #1;
    chk("t5_cnt0",      word_t'(bus.count), 0);
    chk("t5_not_yet",   word_t'(bus.halted), 0);
    tick(); #1;
    chk("t5_halted",    word_t'(bus.halted), 1);
    bus.redirect = 1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 0; bus.ihit = 0;
    #1;
    chk("t5_h_addr", bus.imemaddr, 32'h108);
    chk("t5_h_cnt",  word_t'(bus.count), 0);
    chk("t5_h_flag", word_t'(bus.halted), 1);
    chk("t5_h_ren",  word_t'(bus.imemREN), 0);

    // asynchronous reset clears the halt mid-cycle
    #2; rst = 1; #1;
    chk("t6_rst_halted", word_t'(bus.halted), 0);
    chk("t6_rst_addr",   bus.imemaddr, 32'h0);
    @(negedge clk); rst = 0;

    // PC wrap at the top of the address space
    bus.redirect = 1; bus.redirect_pc = 32'hFFFFFFFF;
    tick();
    bus.redirect = 0; bus.ihit = 1; bus.deq_ready = 0;
    #1;
    chk("t6_addr_top", bus.imemaddr, 32'hFFFFFFFC);
    tick(); #1;
    chk("t6_wrap_pc4",   bus.instr_pc4, 32'h0);
    chk("t6_wrap_instr", bus.instr, 32'h2152FFFC);
    chk("t6_wrap_addr",  bus.imemaddr, 32'h0);
    tick(); #1;
    chk("t6_cnt2", word_t'(bus.count), 2);
    #2; rst = 1; #1;
    chk("t6_rst_cnt",   word_t'(bus.count), 0);
    chk("t6_rst_valid", word_t'(bus.instr_valid), 0);
    chk("t6_rst_pc",    bus.imemaddr, 32'h0);
    chk("t6_rst_ren",   word_t'(bus.imemREN), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
